rr_req_queue: RTL and testbench

//  Requester-side front end for the round-robin arbiter: per-port input FIFOs raise req_o toward the

---
 rtl/rr_pkg.sv | 30 +++
 rtl/rr_port_fifo.sv | 69 ++++++
 rtl/rr_req_queue.sv | 112 +++++++++++
 tb/tb_rr_req_queue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin requester front end and its arbiter.
package rr_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 4;

    // Widest grant vector the helper functions handle.
    localparam int MAX_PORTS     = 32;

    typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [MAX_PORTS-1:0] v);
        logic [MAX_PORTS-1:0] one;
        one = {{(MAX_PORTS-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    // Index of the set bit of a one-hot vector (highest set bit otherwise).
    function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_port_fifo.sv
// Per-port synchronous FIFO: one push and one pop per cycle, head visible combinationally.
module rr_port_fifo
    import rr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // Full/empty come straight from the count; a full FIFO refuses a push even if popped this cycle.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset so queued data is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rr_req_queue.sv
// Requester-side front end: per-port FIFOs raise requests, the accepted one-hot grant pops
// the granted head into a single output register stage.
//
// Handshakes: a word moves on any interface only in a cycle where valid and ready are both 1
// at the rising edge. Upstream: in_valid[p] & in_ready[p]. Downstream: out_valid & out_ready;
// out_valid never drops and out_data/out_port never change until that transfer happens.
// Toward the arbiter, req_o[p] plays the valid role and a legal gnt_i bit plays the ready role.
module rr_req_queue
    import rr_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]     in_data,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            req_o,
    input  logic [NUM_PORTS-1:0]            gnt_i,
    output logic                            out_valid,
    output logic [DATA_W-1:0]               out_data,
    output logic [$clog2(NUM_PORTS)-1:0]    out_port,
    input  logic                            out_ready,
    output logic                            gnt_err
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]    head  [NUM_PORTS];
    logic [CNT_W-1:0]     count [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] pop;
    logic                 stage_free;
    logic                 gnt_ok;
    logic                 gnt_bad;
    logic [IDX_W-1:0]     gnt_idx;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [IDX_W-1:0]     out_port_q,  out_port_d;
    logic                 gnt_err_q,   gnt_err_d;

    // The stage can take a word when empty or draining this cycle (out_ready feeds req_o on purpose).
    assign stage_free = ~out_valid_q | out_ready;

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        rr_port_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
        ) u_fifo (
            .clk_i   (clk),
            .rst_ni  (reset),
            .push_i  (in_valid[gp]),
            .data_i  (in_data[gp*DATA_W +: DATA_W]),
            .pop_i   (pop[gp]),
            .head_o  (head[gp]),
            .count_o (count[gp]),
            .empty_o (empty[gp])
        );

        assign in_ready[gp] = (count[gp] != CNT_W'(DEPTH));
        assign req_o[gp]    = ~empty[gp] & stage_free;
    end

    // Grant check: only a one-hot grant that lands on a raised request is acted on.
    always_comb begin
        gnt_ok  = is_onehot(MAX_PORTS'(gnt_i)) && ((gnt_i & req_o) == gnt_i);
        gnt_bad = (gnt_i != '0) && !gnt_ok;
        gnt_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(gnt_i)));
        pop     = gnt_ok ? gnt_i : '0;
    end

    // Output stage next state: load on accepted grant, otherwise empty on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        gnt_err_d   = gnt_bad;
        if (gnt_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = head[gnt_idx];
            out_port_d  = gnt_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage and grant-error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            gnt_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            gnt_err_q   <= gnt_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed and scoreboard-checked bench for rr_req_queue; the bench plays the arbiter.
module tb_rr_req_queue;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int DP = 4;

    logic            clk;
    logic            reset;
    logic [NP-1:0]   in_valid;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]   in_ready;
    logic [NP-1:0]   req_o;
    logic [NP-1:0]   gnt_i;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_port;
    logic            out_ready;
    logic            gnt_err;

    int n_vec;
    int n_err;

    logic [DW-1:0] exp_q [NP][$];

    rr_req_queue #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req_o     (req_o),
        .gnt_i     (gnt_i),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready),
        .gnt_err   (gnt_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int p, input logic [DW-1:0] d);
        in_data[p*DW +: DW] = d;
    endtask

    task automatic chk_out(input string tag, input logic [DW-1:0] d, input logic [1:0] p);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_port"},  32'(out_port),  32'(p));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        gnt_i     = '0;
        out_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_port",  32'(out_port),  32'd0);
        chk("rst_req",       32'(req_o),     32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'hF);
        chk("rst_gnt_err",   32'(gnt_err),   32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single word through port 2
        in_valid = 4'b0100;
        set_data(2, 8'hA5);
        tick();
        in_valid = '0;
        settle();
        chk("t2_req", 32'(req_o), 32'b0100);
        gnt_i = 4'b0100;
        tick();
        gnt_i = '0;
        chk_out("t2_out", 8'hA5, 2'd2);
        settle();
        chk("t2_req_empty", 32'(req_o), 32'h0);
        tick();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // Fill port 0, overflow push ignored, drain in order, wrap pointers
        for (int i = 0; i < DP; i++) begin
            in_valid = 4'b0001;
            set_data(0, 8'(8'h10 + i));
            tick();
        end
        in_valid = '0;
        settle();
        chk("t3_full", 32'(in_ready), 32'hE);
        in_valid = 4'b0001;
        set_data(0, 8'h14);
        tick();
        in_valid = '0;
        chk("t3_still_full", 32'(in_ready), 32'hE);
        for (int i = 0; i < DP; i++) begin
            gnt_i = 4'b0001;
            tick();
            chk_out("t3_drain", 8'(8'h10 + i), 2'd0);
        end
        gnt_i = '0;
        settle();
        chk("t3_ready_back", 32'(in_ready), 32'hF);
        chk("t3_req_empty",  32'(req_o),    32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            in_valid = 4'b0001;
            set_data(0, 8'(8'h20 + i));
            tick();
        end
        in_valid = '0;
        for (int i = 0; i < 2; i++) begin
            gnt_i = 4'b0001;
            tick();
            chk_out("t3_wrap", 8'(8'h20 + i), 2'd0);
        end
        gnt_i = '0;
        tick();
        chk("t3_idle", 32'(out_valid), 32'd0);

        // Backpressure then back-to-back release
        for (int i = 0; i < 2; i++) begin
            in_valid = 4'b0010;
            set_data(1, 8'(8'h30 + i));
            tick();
        end
        in_valid = '0;
        gnt_i = 4'b0010;
        tick();
        gnt_i = '0;
        chk_out("t4_first", 8'h30, 2'd1);
        out_ready = 1'b0;
        settle();
        chk("t4_req_blocked", 32'(req_o), 32'h0);
        tick();
        chk_out("t4_hold1", 8'h30, 2'd1);
        tick();
        chk_out("t4_hold2", 8'h30, 2'd1);
        out_ready = 1'b1;
        gnt_i = 4'b0010;
        settle();
        chk("t4_req_open", 32'(req_o), 32'b0010);
        tick();
        gnt_i = '0;
        chk_out("t4_b2b", 8'h31, 2'd1);
        tick();
        chk("t4_idle", 32'(out_valid), 32'd0);

        // Illegal grants
        in_valid = 4'b0011;
        set_data(0, 8'h40);
        set_data(1, 8'h50);
        tick();
        in_valid = '0;
        settle();
        chk("t5_req", 32'(req_o), 32'b0011);
        gnt_i = 4'b0011;
        tick();
        gnt_i = '0;
        chk("t5_err_multi",   32'(gnt_err),   32'd1);
        chk("t5_nolaod_multi", 32'(out_valid), 32'd0);
        gnt_i = 4'b1000;
        tick();
        gnt_i = '0;
        chk("t5_err_noreq", 32'(gnt_err),   32'd1);
        chk("t5_noload_noreq", 32'(out_valid), 32'd0);
        tick();
        chk("t5_err_clear", 32'(gnt_err), 32'd0);
        chk("t5_req_kept",  32'(req_o),   32'b0011);
        gnt_i = 4'b0001;
        tick();
        chk_out("t5_p0", 8'h40, 2'd0);
        gnt_i = 4'b0010;
        tick();
        chk_out("t5_p1", 8'h50, 2'd1);
        gnt_i = '0;
        tick();
        chk("t5_idle", 32'(out_valid), 32'd0);
        chk("t5_empty", 32'(req_o), 32'h0);

        // Simultaneous push and pop on a one-entry port
        in_valid = 4'b1000;
        set_data(3, 8'h60);
        tick();
        set_data(3, 8'h61);
        gnt_i = 4'b1000;
        tick();
        in_valid = '0;
        gnt_i = '0;
        chk_out("t6_first", 8'h60, 2'd3);
        settle();
        chk("t6_one_left", 32'(req_o), 32'b1000);
        gnt_i = 4'b1000;
        tick();
        gnt_i = '0;
        chk_out("t6_second", 8'h61, 2'd3);
        settle();
        chk("t6_empty", 32'(req_o), 32'h0);
        tick();

        // Random soak against a per-port scoreboard
        begin
            logic          m_valid;
            logic [DW-1:0] m_data;
            logic [1:0]    m_port;
            logic          m_sf;
            logic [NP-1:0] m_req;
            logic [NP-1:0] m_rdy;
            int            cand[$];
            int            g;
            m_valid = out_valid;
            m_data  = out_data;
            m_port  = out_port;
            for (int cyc = 0; cyc < 400; cyc++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = 4'($urandom_range(0, 15));
                for (int p = 0; p < NP; p++) set_data(p, 8'($urandom_range(0, 255)));
                m_sf = !m_valid || out_ready;
                cand.delete();
                for (int p = 0; p < NP; p++) begin
                    m_req[p] = (exp_q[p].size() != 0) && m_sf;
                    m_rdy[p] = (exp_q[p].size() != DP);
                    if (m_req[p]) cand.push_back(p);
                end
                g = -1;
                if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                    g = cand[$urandom_range(0, cand.size() - 1)];
                gnt_i = (g >= 0) ? 4'(1 << g) : 4'h0;
                settle();
                chk("soak_req",      32'(req_o),    32'(m_req));
                chk("soak_in_ready", 32'(in_ready), 32'(m_rdy));
                if (g >= 0) begin
                    m_data  = exp_q[g].pop_front();
                    m_port  = 2'(g);
                    m_valid = 1'b1;
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
                for (int p = 0; p < NP; p++)
                    if (in_valid[p] && m_rdy[p]) exp_q[p].push_back(in_data[p*DW +: DW]);
                tick();
                chk("soak_valid", 32'(out_valid), 32'(m_valid));
                if (m_valid) begin
                    chk("soak_data", 32'(out_data), 32'(m_data));
                    chk("soak_port", 32'(out_port), 32'(m_port));
                end
            end
            in_valid  = '0;
            gnt_i     = '0;
            out_ready = 1'b1;
        end

        // Reset in the middle of traffic
        in_valid = 4'b0111;
        set_data(0, 8'h70);
        set_data(1, 8'h71);
        set_data(2, 8'h72);
        tick();
        in_valid = '0;
        gnt_i = 4'b0001;
        tick();
        gnt_i = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_data",     32'(out_data),  32'd0);
        chk("mid_rst_req",      32'(req_o),     32'h0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'hF);
        chk("mid_rst_gnt_err",  32'(gnt_err),   32'd0);
        tick();
        chk("mid_rst_hold_req", 32'(req_o), 32'h0);
        reset = 1'b1;
        tick();
        chk("post_rst_empty", 32'(req_o),     32'h0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
